// File: rtl/romupload.sv
// Upload manager: answers HPS IOCTL upload reads with bytes fetched from on-chip memory,
// stalling IOCTL_WAIT until each byte is ready and flagging the session for the memory mux.
module romupload #(
    parameter int                ADDR_W         = 17,
    parameter logic [ADDR_W-1:0] MEM_SIZE       = 17'h10000,
    parameter logic [7:0]        FILL           = 8'hFF,
    parameter logic [5:0]        UPLOAD_MENUSUB = 6'd2
) (
    input  logic              CLK_SYS,
    input  logic              RESET,
    input  logic              IOCTL_UPLOAD,
    input  logic [15:0]       IOCTL_INDEX,
    input  logic              IOCTL_RD,
    input  logic [26:0]       IOCTL_ADDR,
    output logic [7:0]        IOCTL_DIN,
    output logic              IOCTL_WAIT,
    output logic              UPLOAD_ACTIVE,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [7:0]        MEM_DATA
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // The range check uses all 27 address bits so high addresses never alias into memory.
    localparam logic [26:0] SIZE_LIMIT = 27'(MEM_SIZE);

    state_t            state;
    state_t            state_next;
    logic              sel;
    logic              in_range;
    logic [7:0]        din_next;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic              unused_index;

    assign sel          = IOCTL_UPLOAD & (IOCTL_INDEX[5:0] == UPLOAD_MENUSUB);
    assign in_range     = IOCTL_ADDR < SIZE_LIMIT;
    assign IOCTL_WAIT   = (IOCTL_RD & sel) | (state != IDLE);
    assign unused_index = ^IOCTL_INDEX[15:6];

    always_comb begin
        state_next = state;
        din_next   = IOCTL_DIN;
        req_next   = MEM_REQ;
        addr_next  = MEM_ADDR;
        case (state)
            IDLE: begin
                if (IOCTL_RD) begin
                    if (!sel) begin
                        din_next = FILL;
                    end else if (in_range) begin
                        addr_next  = IOCTL_ADDR[ADDR_W-1:0];
                        req_next   = 1'b1;
                        state_next = REQ;
                    end else begin
                        din_next   = FILL;
                        state_next = DONE;
                    end
                end
            end
            // Once issued, a request is always completed, even if the session ends meanwhile.
            REQ: begin
                if (MEM_ACK) begin
                    din_next   = MEM_DATA;
                    req_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            IOCTL_DIN     <= 8'h00;
            MEM_REQ       <= 1'b0;
            MEM_ADDR      <= '0;
            UPLOAD_ACTIVE <= 1'b0;
        end else begin
            state         <= state_next;
            IOCTL_DIN     <= din_next;
            MEM_REQ       <= req_next;
            MEM_ADDR      <= addr_next;
            UPLOAD_ACTIVE <= sel;
        end
    end

endmodule
